button_debouncer: RTL and testbench

- Debounces one raw push-button input using the 100 Hz divided clock (s_clk) from the clock divider stage.
- Sits directly downstream of the divider and upstream of the control FSMs that consume button events.
- Runs entirely in the clk domain. s_clk is treated as data and converted to a one-cycle sample tick, so there is no second clock domain.
- Outputs a clean level plus a one-clk-cycle press pulse.

---
 rtl/button_debouncer.sv | 219 +++++++++++++++++++++
 tb/tb_button_debouncer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer
// Debounces one raw push-button against the ~100 Hz divided clock s_clk.
// s_clk is treated as data: it is synchronized into clk and edge-detected
// into a one-cycle sample tick, so the whole block lives in the clk domain.
// Outputs a registered debounced level and a one-cycle press pulse.
//
// Optional feature: define AUTOREPEAT_EN to add hold-to-repeat pulses
// (first repeat after REPEAT_DELAY ticks, then every REPEAT_RATE ticks).
//
// state           | meaning
// ----------------+------------------------------------------------------
// IDLE            | released and stable, waiting for a high sample
// CONFIRM_PRESS   | counting consecutive high samples toward acceptance
// PRESSED         | press accepted, level high, waiting for a low sample
// CONFIRM_RELEASE | counting consecutive low samples, level still high

module button_debouncer #(
   parameter int STABLE_SAMPLES = 4,
   parameter int CNT_W          = 3,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_RATE    = 10,
   parameter int REPEAT_W       = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic s_clk,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_pulse
);

   typedef enum logic [1:0] {
      IDLE            = 2'd0,
      CONFIRM_PRESS   = 2'd1,
      PRESSED         = 2'd2,
      CONFIRM_RELEASE = 2'd3
   } state_t;

   // Sample count compared one bit wider than the counter so cnt+1 never wraps.
   localparam logic [CNT_W:0] STABLE_N      = (CNT_W+1)'(STABLE_SAMPLES);
   localparam bit             SINGLE_SAMPLE = (STABLE_SAMPLES == 1);

   // Synchronizer flops
   logic btn_meta_q,  btn_meta_d;
   logic btn_sync_q,  btn_sync_d;
   logic sclk_meta_q, sclk_meta_d;
   logic sclk_sync_q, sclk_sync_d;
   logic sclk_dly_q,  sclk_dly_d;

   // FSM flops
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;

   logic             btn_s;
   logic             tick;
   logic [CNT_W:0]   cnt_inc;
   logic             press_accept;
   logic             repeat_fire;

`ifdef AUTOREPEAT_EN
   localparam logic [REPEAT_W-1:0] DELAY_N = REPEAT_W'(REPEAT_DELAY);
   localparam logic [REPEAT_W-1:0] RATE_N  = REPEAT_W'(REPEAT_RATE);

   logic [REPEAT_W-1:0] rcnt_q, rcnt_d;
   logic                rarmed_q, rarmed_d;
   logic [REPEAT_W-1:0] rcnt_inc;
   logic [REPEAT_W-1:0] rcnt_target;
`endif

   // Synchronizer next-state: two flops per async input plus an s_clk delay flop
   always_comb begin
      btn_meta_d  = btn_in;
      btn_sync_d  = btn_meta_q;
      sclk_meta_d = s_clk;
      sclk_sync_d = sclk_meta_q;
      sclk_dly_d  = sclk_sync_q;
   end

   assign btn_s   = btn_sync_q;
   assign tick    = sclk_sync_q & ~sclk_dly_q;
   assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

   // Debounce FSM next-state: only moves on a sample tick
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      press_accept = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (btn_s) begin
                  if (SINGLE_SAMPLE) begin
                     state_d      = PRESSED;
                     cnt_d        = '0;
                     press_accept = 1'b1;
                  end else begin
                     state_d = CONFIRM_PRESS;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            CONFIRM_PRESS: begin
               if (btn_s) begin
                  if (cnt_inc == STABLE_N) begin
                     state_d      = PRESSED;
                     cnt_d        = '0;
                     press_accept = 1'b1;
                  end else begin
                     cnt_d = cnt_inc[CNT_W-1:0];
                  end
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            PRESSED: begin
               if (!btn_s) begin
                  if (SINGLE_SAMPLE) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = CONFIRM_RELEASE;
                     cnt_d   = CNT_W'(1);
                  end
               end
            end
            CONFIRM_RELEASE: begin
               if (!btn_s) begin
                  if (cnt_inc == STABLE_N) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc[CNT_W-1:0];
                  end
               end else begin
                  // Bounce during release: back to PRESSED without a new pulse
                  state_d = PRESSED;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

`ifdef AUTOREPEAT_EN
   assign rcnt_inc    = rcnt_q + {{(REPEAT_W-1){1'b0}}, 1'b1};
   assign rcnt_target = rarmed_q ? RATE_N : DELAY_N;

   // Auto-repeat counter: counts held ticks in PRESSED, frozen in CONFIRM_RELEASE
   always_comb begin
      rcnt_d      = rcnt_q;
      rarmed_d    = rarmed_q;
      repeat_fire = 1'b0;
      if (press_accept || (state_d == IDLE)) begin
         rcnt_d   = '0;
         rarmed_d = 1'b0;
      end else if (tick && (state_q == PRESSED) && (state_d == PRESSED)) begin
         if (rcnt_inc == rcnt_target) begin
            repeat_fire = 1'b1;
            rcnt_d      = '0;
            rarmed_d    = 1'b1;
         end else begin
            rcnt_d = rcnt_inc;
         end
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

   // Output next-state: level follows the accepted state, pulse on accept/repeat
   always_comb begin
      level_d = (state_d == PRESSED) || (state_d == CONFIRM_RELEASE);
      pulse_d = press_accept | repeat_fire;
   end

   // All state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_meta_q  <= 1'b0;
         btn_sync_q  <= 1'b0;
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_dly_q  <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         pulse_q     <= 1'b0;
`ifdef AUTOREPEAT_EN
         rcnt_q      <= '0;
         rarmed_q    <= 1'b0;
`endif
      end else begin
         btn_meta_q  <= btn_meta_d;
         btn_sync_q  <= btn_sync_d;
         sclk_meta_q <= sclk_meta_d;
         sclk_sync_q <= sclk_sync_d;
         sclk_dly_q  <= sclk_dly_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         pulse_q     <= pulse_d;
`ifdef AUTOREPEAT_EN
         rcnt_q      <= rcnt_d;
         rarmed_q    <= rarmed_d;
`endif
      end
   end

   assign btn_level = level_q;
   assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer: randomized per-tick samples, a run-length
// reference model, and a queue scoreboard drained by an output monitor.

module tb_button_debouncer;

   localparam int N        = 4;
   localparam int R_DELAY  = 5;
   localparam int R_RATE   = 2;
   localparam int LATENCY  = 3;   // s_clk rise drive -> registered outputs

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic s_clk = 1'b0;
   logic btn_in = 1'b0;
   logic btn_level;
   logic btn_pulse;

   button_debouncer #(
      .STABLE_SAMPLES (N),
      .CNT_W          (3),
      .REPEAT_DELAY   (R_DELAY),
      .REPEAT_RATE    (R_RATE),
      .REPEAT_W       (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .s_clk     (s_clk),
      .btn_in    (btn_in),
      .btn_level (btn_level),
      .btn_pulse (btn_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int passes = 0;

   // Scoreboard queues: expected cycle of each pulse / level change
   int pulse_q[$];
   int lvl_cyc_q[$];
   bit lvl_val_q[$];

   // Reference model: level flips once N consecutive samples disagree with it
   bit m_level = 1'b0;
   int m_run   = 0;
`ifdef AUTOREPEAT_EN
   int m_held  = 0;
   bit m_armed = 1'b0;
`endif

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_sample(input bit b, input int c);
      if (b != m_level) begin
         m_run++;
         if (m_run == N) begin
            m_level = b;
            m_run   = 0;
            lvl_cyc_q.push_back(c + LATENCY);
            lvl_val_q.push_back(b);
            if (b) begin
               pulse_q.push_back(c + LATENCY);
`ifdef AUTOREPEAT_EN
               m_held  = 0;
               m_armed = 1'b0;
`endif
            end
         end
      end else begin
`ifdef AUTOREPEAT_EN
         if (m_level && m_run == 0) begin
            m_held++;
            if (m_held == (m_armed ? R_RATE : R_DELAY)) begin
               pulse_q.push_back(c + LATENCY);
               m_held  = 0;
               m_armed = 1'b1;
            end
         end
`endif
         m_run = 0;
      end
   endtask

   // One sample period: low phase with btn driven (optional glitch), then rise
   task automatic do_tick(input bit b, input bit glitch);
      btn_in = b;
      repeat (2) @(negedge clk);
      if (glitch) begin
         btn_in = ~b;
         repeat (2) @(negedge clk);
         btn_in = b;
         repeat (6) @(negedge clk);
      end else begin
         repeat (8) @(negedge clk);
      end
      s_clk = 1'b1;
      model_sample(b, cyc);
      repeat (10) @(negedge clk);
      s_clk = 1'b0;
   endtask

   task automatic ticks(input bit b, input int n);
      for (int i = 0; i < n; i++) do_tick(b, 1'b0);
   endtask

   task automatic reset_now(input string name);
      reset = 1'b0;
      #1;
      check(btn_level == 1'b0, {name, "_level"}, btn_level, 0);
      check(btn_pulse == 1'b0, {name, "_pulse"}, btn_pulse, 0);
      m_level = 1'b0;
      m_run   = 0;
`ifdef AUTOREPEAT_EN
      m_held  = 0;
      m_armed = 1'b0;
`endif
      pulse_q.delete();
      lvl_cyc_q.delete();
      lvl_val_q.delete();
      repeat (4) @(negedge clk);
      reset = 1'b1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT pulses or changes level
   bit prev_level = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_level = 1'b0;
      end else begin
         if (btn_pulse) begin
            check(pulse_q.size() > 0, "pulse_expected", pulse_q.size(), 1);
            if (pulse_q.size() > 0) begin
               automatic int e = pulse_q.pop_front();
               check(cyc == e, "pulse_cycle", cyc, e);
               check(btn_level == 1'b1, "level_at_pulse", btn_level, 1);
            end
         end
         if (btn_level !== prev_level) begin
            check(lvl_cyc_q.size() > 0, "level_change_expected", lvl_cyc_q.size(), 1);
            if (lvl_cyc_q.size() > 0) begin
               automatic int e = lvl_cyc_q.pop_front();
               automatic bit v = lvl_val_q.pop_front();
               check(cyc == e, "level_cycle", cyc, e);
               check(btn_level == v, "level_value", btn_level, v);
            end
            prev_level = btn_level;
         end
      end
   end

   initial begin
      bit cur;

      // Reset held with button pressed and s_clk toggling: outputs stay low
      btn_in = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i % 10 == 0) s_clk = ~s_clk;
         check(btn_level == 1'b0 && btn_pulse == 1'b0, "in_reset_outputs",
               {btn_level, btn_pulse}, 0);
      end
      s_clk  = 1'b0;
      btn_in = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      ticks(1'b0, 3);
      check(btn_level == 1'b0, "after_reset_level", btn_level, 0);

      // Clean press held 10 ticks, then clean release
      ticks(1'b1, 10);
      ticks(1'b0, 6);

      // Press bounce 1,1,0,1,1,1,1
      do_tick(1'b1, 1'b0); do_tick(1'b1, 1'b0); do_tick(1'b0, 1'b0);
      ticks(1'b1, 4);
      ticks(1'b1, 2);

      // Release bounce 0,0,1,0,0,0,0
      do_tick(1'b0, 1'b0); do_tick(1'b0, 1'b0); do_tick(1'b1, 1'b0);
      check(btn_level == 1'b1, "release_bounce_level", btn_level, 1);
      ticks(1'b0, 4);
      ticks(1'b0, 2);

      // Reset mid-confirm after two high samples, then a full new press needed
      ticks(1'b1, 2);
      reset_now("reset_mid_confirm");
      ticks(1'b1, 3);
      check(btn_level == 1'b0, "post_reset_partial", btn_level, 0);
      ticks(1'b1, 1);
      check(btn_level == 1'b1, "post_reset_full", btn_level, 1);

      // Long hold (auto-repeat pulses when enabled, one pulse otherwise)
      ticks(1'b1, 14);
      ticks(1'b0, 5);

      // Randomized samples with occasional between-tick glitches
      cur = 1'b0;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) cur = ~cur;
         do_tick(cur, $urandom_range(0, 4) == 0);
      end

      // Reset while pressed drops the level immediately
      ticks(1'b1, 6);
      reset_now("reset_pressed");
      ticks(1'b0, 2);

      // s_clk stuck low: button activity must not move the outputs
      ticks(1'b1, 5);
      btn_in = 1'b0;
      repeat (80) @(negedge clk);
      check(btn_level == m_level, "stuck_sclk_level", btn_level, m_level);
      ticks(1'b0, 6);

      repeat (10) @(negedge clk);
      check(pulse_q.size() == 0, "pending_pulses", pulse_q.size(), 0);
      check(lvl_cyc_q.size() == 0, "pending_level_changes", lvl_cyc_q.size(), 0);
      check(btn_level == m_level, "final_level", btn_level, m_level);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
